// File: rtl/dm_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_dump_ctrl
// Brief    : Streams a window of data memory out through the UART, two bytes
//            per word, high byte first. Optional trailing XOR checksum byte
//            when DUMP_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module dm_dump_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              RdDM,
    output logic [ADDR_W-1:0] outAddr,
    input  logic [DATA_W-1:0] inData,
    output logic              tx_start,
    output logic [7:0]        d_out,
    input  logic              tx_done,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RD_REQ  = 4'd1,
        S_RD_CAP  = 4'd2,
        S_SEND_HI = 4'd3,
        S_WAIT_HI = 4'd4,
        S_SEND_LO = 4'd5,
        S_WAIT_LO = 4'd6,
`ifdef DUMP_CHECKSUM_EN
        S_SEND_CK = 4'd7,
        S_WAIT_CK = 4'd8,
`endif
        S_FINISH  = 4'd9
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Where the sequence goes once the data words are exhausted.
`ifdef DUMP_CHECKSUM_EN
    localparam state_t c_after_data = S_SEND_CK;
`else
    localparam state_t c_after_data = S_FINISH;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] r_remain;
    logic [ADDR_W-1:0] w_remain_nxt;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] w_word_nxt;
    logic              r_abort_pend;
    logic              w_abort_nxt;
    logic [7:0]        w_hi;
    logic [7:0]        w_lo;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        r_ck;
    logic [7:0]        w_ck_nxt;
`endif

    assign w_hi = r_word[DATA_W-1 -: 8];
    assign w_lo = r_word[7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_remain     <= '0;
            r_word       <= '0;
            r_abort_pend <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            r_ck         <= 8'h00;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_remain     <= w_remain_nxt;
            r_word       <= w_word_nxt;
            r_abort_pend <= w_abort_nxt;
`ifdef DUMP_CHECKSUM_EN
            r_ck         <= w_ck_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_remain_nxt = r_remain;
        w_word_nxt   = r_word;
        w_abort_nxt  = r_abort_pend;
`ifdef DUMP_CHECKSUM_EN
        w_ck_nxt     = r_ck;
`endif
        RdDM         = 1'b0;
        outAddr      = r_addr;
        tx_start     = 1'b0;
        d_out        = 8'h00;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        aborted      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_addr_nxt   = base_addr;
                    w_remain_nxt = count;
                    w_abort_nxt  = abort;
`ifdef DUMP_CHECKSUM_EN
                    w_ck_nxt     = 8'h00;
`endif
                    if (abort)
                        w_state_nxt = S_FINISH;
                    else if (count != '0)
                        w_state_nxt = S_RD_REQ;
                    else
                        w_state_nxt = c_after_data;
                end
            end
            S_RD_REQ: begin
                RdDM = 1'b1;
                if (abort) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_state_nxt = S_RD_CAP;
                end
            end
            S_RD_CAP: begin
                if (abort) begin
                    w_abort_nxt = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    w_word_nxt  = inData;
                    w_state_nxt = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                d_out    = w_hi;
                tx_start = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                w_ck_nxt = r_ck ^ w_hi;
`endif
                if (abort) w_abort_nxt = 1'b1;
                w_state_nxt = S_WAIT_HI;
            end
            // A pending abort still lets the current word finish its low byte.
            S_WAIT_HI: begin
                d_out = w_hi;
                if (abort) w_abort_nxt = 1'b1;
                if (tx_done) w_state_nxt = S_SEND_LO;
            end
            S_SEND_LO: begin
                d_out    = w_lo;
                tx_start = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                w_ck_nxt = r_ck ^ w_lo;
`endif
                if (abort) w_abort_nxt = 1'b1;
                w_state_nxt = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                d_out = w_lo;
                if (abort) w_abort_nxt = 1'b1;
                if (tx_done) begin
                    w_addr_nxt   = r_addr + c_addr_one;
                    w_remain_nxt = r_remain - c_addr_one;
                    if (r_abort_pend || abort)
                        w_state_nxt = S_FINISH;
                    else if (r_remain == c_addr_one)
                        w_state_nxt = c_after_data;
                    else
                        w_state_nxt = S_RD_REQ;
                end
            end
`ifdef DUMP_CHECKSUM_EN
            S_SEND_CK: begin
                d_out    = r_ck;
                tx_start = 1'b1;
                if (abort) w_abort_nxt = 1'b1;
                w_state_nxt = S_WAIT_CK;
            end
            S_WAIT_CK: begin
                d_out = r_ck;
                if (abort) w_abort_nxt = 1'b1;
                if (tx_done) w_state_nxt = S_FINISH;
            end
`endif
            S_FINISH: begin
                done        = ~r_abort_pend;
                aborted     = r_abort_pend;
                w_abort_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_dump_ctrl
// Brief    : Scoreboard bench for dm_dump_ctrl with memory and UART models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_dump_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] count = '0;
    logic        RdDM;
    logic [11:0] outAddr;
    logic [15:0] inData = '0;
    logic        tx_start;
    logic [7:0]  d_out;
    logic        tx_done;
    logic        uart_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        busy;
    logic        done;
    logic        aborted;

    assign tx_done = uart_done | stray_done;

    dm_dump_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .count(count), .RdDM(RdDM), .outAddr(outAddr),
        .inData(inData), .tx_start(tx_start), .d_out(d_out), .tx_done(tx_done),
        .busy(busy), .done(done), .aborted(aborted)
    );

    initial forever #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    logic [7:0]  exp_q [$];
    logic [11:0] addr_log [$];
    int          tx_cyc [$];
    int          checks = 0;
    int          errors = 0;
    int          n_tx = 0, n_rd = 0, n_done = 0, n_aborted = 0;
    int          cyc = 0;
    int          uart_cnt = 0;

    // Memory responder, UART responder and byte scoreboard, all on the falling edge.
    task automatic monitor();
        logic [7:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            uart_done = 1'b0;
            if (uart_cnt != 0) begin
                uart_cnt--;
                if (uart_cnt == 0) uart_done = 1'b1;
            end
            if (RdDM) begin
                inData = mem[outAddr];
                n_rd++;
                addr_log.push_back(outAddr);
            end
            if (done) n_done++;
            if (aborted) n_aborted++;
            if (tx_start) begin
                n_tx++;
                uart_cnt = 10;
                tx_cyc.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte: got unexpected byte %02h, required none", d_out);
                end else begin
                    b = exp_q.pop_front();
                    if (d_out !== b) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h, required %02h", d_out, b);
                    end
                end
            end
        end
    endtask

    task automatic push_words(input logic [11:0] b, input int c);
        logic [7:0]  ck;
        logic [11:0] a;
        ck = 8'h00;
        for (int i = 0; i < c; i++) begin
            a = b + 12'(i);
            exp_q.push_back(mem[a][15:8]);
            exp_q.push_back(mem[a][7:0]);
            ck = ck ^ mem[a][15:8] ^ mem[a][7:0];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(ck);
`endif
    endtask

    task automatic pulse_start(input logic [11:0] b, input logic [11:0] c);
        @(negedge clk);
        base_addr = b;
        count = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n0;
        bit seen;
        n0 = n_done + n_aborted;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (n_done + n_aborted != n0) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_end: no done/aborted within 3000 cycles");
        end
        @(negedge clk);
    endtask

    localparam int c_ck = (`ifdef DUMP_CHECKSUM_EN 1 `else 0 `endif);

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({RdDM, outAddr, tx_start, d_out, busy, done, aborted} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0",
                     {RdDM, outAddr, tx_start, d_out, busy, done, aborted});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int tx0, d0, a0;
        mem[12'h010] = 16'hBEEF;
        mem[12'h011] = 16'h1234;
        tx0 = n_tx; d0 = n_done; a0 = n_aborted;
        tx_cyc.delete();
        push_words(12'h010, 2);
        @(negedge clk);
        base_addr = 12'h010; count = 12'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({RdDM, outAddr, busy} !== {1'b1, 12'h010, 1'b1}) begin
            errors++;
            $display("FAIL first_read: got RdDM=%b addr=%h busy=%b, required 1 010 1", RdDM, outAddr, busy);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({tx_start, d_out} !== {1'b1, 8'hBE}) begin
            errors++;
            $display("FAIL first_tx: got tx_start=%b d_out=%h, required 1 BE", tx_start, d_out);
        end
        wait_end();
        checks++;
        if ((n_tx - tx0) != 4 + c_ck || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_bytes: got %0d bytes, %0d left, required %0d, 0", n_tx - tx0, exp_q.size(), 4 + c_ck);
        end
        checks++;
        if ((n_done - d0) != 1 || (n_aborted - a0) != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%0d aborted=%0d busy=%b, required 1 0 0", n_done - d0, n_aborted - a0, busy);
        end
        checks++;
        if (tx_cyc.size() < 4 || tx_cyc[1] - tx_cyc[0] != 11 || tx_cyc[2] - tx_cyc[1] != 13 ||
            tx_cyc[3] - tx_cyc[2] != 11) begin
            errors++;
            $display("FAIL basic_gaps: got %0d tx launches with wrong spacing, required gaps 11 13 11", tx_cyc.size());
        end
    endtask

    task automatic test_wrap();
        int tx0;
        mem[12'hFFF] = 16'hA55A;
        mem[12'h000] = 16'h0F0F;
        tx0 = n_tx;
        addr_log.delete();
        push_words(12'hFFF, 2);
        pulse_start(12'hFFF, 12'd2);
        wait_end();
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 12'hFFF || addr_log[1] !== 12'h000) begin
            errors++;
            $display("FAIL wrap_addr: got %0d reads, required FFF then 000", addr_log.size());
        end
        checks++;
        if ((n_tx - tx0) != 4 + c_ck || exp_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_bytes: got %0d, required %0d", n_tx - tx0, 4 + c_ck);
        end
    endtask

    task automatic test_zero();
        int tx0, rd0, d0;
        tx0 = n_tx; rd0 = n_rd; d0 = n_done;
        push_words(12'h100, 0);
        @(negedge clk);
        base_addr = 12'h100; count = 12'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
`ifdef DUMP_CHECKSUM_EN
        if ({tx_start, d_out, RdDM} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL zero_first: got tx_start=%b d_out=%h RdDM=%b, required 1 00 0", tx_start, d_out, RdDM);
        end
`else
        if ({done, RdDM, tx_start} !== 3'b100) begin
            errors++;
            $display("FAIL zero_first: got done=%b RdDM=%b tx_start=%b, required 1 0 0", done, RdDM, tx_start);
        end
`endif
        wait_end();
        checks++;
        if ((n_rd - rd0) != 0 || (n_tx - tx0) != c_ck || (n_done - d0) != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_count: got rd=%0d tx=%0d done=%0d, required 0 %0d 1", n_rd - rd0, n_tx - tx0, n_done - d0, c_ck);
        end
    endtask

    task automatic test_abort();
        int tx0, d0, a0, rd0;
        mem[12'h020] = 16'hC001;
        mem[12'h021] = 16'hD002;
        mem[12'h022] = 16'hE003;
        tx0 = n_tx; d0 = n_done; a0 = n_aborted; rd0 = n_rd;
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'h01);
        pulse_start(12'h020, 12'd3);
        for (int i = 0; i < 100 && n_tx == tx0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_end();
        checks++;
        if ((n_tx - tx0) != 2 || exp_q.size() != 0 || (n_rd - rd0) != 1) begin
            errors++;
            $display("FAIL abort_bytes: got tx=%0d rd=%0d, required 2 1", n_tx - tx0, n_rd - rd0);
        end
        checks++;
        if ((n_aborted - a0) != 1 || (n_done - d0) != 0) begin
            errors++;
            $display("FAIL abort_pulse: got aborted=%0d done=%0d, required 1 0", n_aborted - a0, n_done - d0);
        end
    endtask

    task automatic test_reset_mid();
        int tx0, d0;
        mem[12'h030] = 16'h5AA5;
        mem[12'h031] = 16'h3CC3;
        tx0 = n_tx;
        push_words(12'h030, 2);
        pulse_start(12'h030, 12'd2);
        for (int i = 0; i < 200 && n_tx < tx0 + 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({RdDM, outAddr, tx_start, d_out, busy, done, aborted} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h, required 0",
                     {RdDM, outAddr, tx_start, d_out, busy, done, aborted});
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tx0 = n_tx;
        repeat (20) @(negedge clk);
        checks++;
        if (n_tx != tx0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_late_done: got %0d extra bytes busy=%b, required 0 0", n_tx - tx0, busy);
        end
        tx0 = n_tx; d0 = n_done;
        push_words(12'h010, 2);
        pulse_start(12'h010, 12'd2);
        wait_end();
        checks++;
        if ((n_tx - tx0) != 4 + c_ck || (n_done - d0) != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_redump: got tx=%0d done=%0d, required %0d 1", n_tx - tx0, n_done - d0, 4 + c_ck);
        end
    endtask

    task automatic test_stray();
        int tx0, rd0;
        tx0 = n_tx;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (n_tx != tx0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: got tx=%0d busy=%b, required 0 0", n_tx - tx0, busy);
        end
        tx0 = n_tx; rd0 = n_rd;
        push_words(12'h010, 1);
        pulse_start(12'h010, 12'd1);
        repeat (4) @(negedge clk);
        pulse_start(12'h500, 12'd5);
        wait_end();
        checks++;
        if ((n_tx - tx0) != 2 + c_ck || (n_rd - rd0) != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stray_start: got tx=%0d rd=%0d, required %0d 1", n_tx - tx0, n_rd - rd0, 2 + c_ck);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_wrap();
        test_zero();
        test_abort();
        test_reset_mid();
        test_stray();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
